watch_adjust_seq: RTL
=====================

# watch_adjust_seq

Auto-repeat adjust sequencer for the watch time-setting path. Takes the one-hot field select from the watch control unit and debounced up/down button levels, and issues single-cycle increment/decrement pulses to the selected sec/min/hour counter. A press gives one immediate step; a held button gives repeated steps after a hold delay. Sits between the button debouncers / watch control unit and the watch time datapath.

## Interface
- HOLD_CYC, default 50_000_000: cycles from first pulse to second pulse while held; legal range ≥2.
- REPEAT_CYC, default 10_000_000: cycles between subsequent repeat pulses; legal range ≥2.
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  adjust mode enable (watch mode, not stopwatch).
- sel_sec / sel_min / sel_hour  in  1 each  field select; valid only when exactly one is high.
- btn_up / btn_down  in  1 each  debounced button levels, already synchronous to clk.
- inc_sec, dec_sec, inc_min, dec_min, inc_hour, dec_hour  out  1 each  registered single-cycle step pulses.
- busy  out  1  high in DELAY or REPEAT.

## Operation
- "Valid request": en=1, exactly one sel_* high, exactly one of btn_up/btn_down high.
- States: LOCK, IDLE, DELAY, REPEAT. Reset enters LOCK.
- LOCK: no pulses; when btn_up=0 and btn_down=0, go to IDLE. A button held through reset never steps.
- IDLE: on a valid request, latch direction and field, emit one pulse, clear the counter, go to DELAY. Otherwise stay.
- DELAY: while the latched button is still high, the other button is low, the select is unchanged and en=1:
  - increment the counter;
  - when the counter reaches HOLD_CYC-1, emit a pulse, clear the counter, go to REPEAT.
- REPEAT: same hold conditions as DELAY; pulse each time the counter reaches REPEAT_CYC-1, then clear.
- Exits from DELAY/REPEAT:
  - latched button released, other button low → IDLE;
  - other button pressed, select changed, or en dropped → LOCK.
- Both buttons high in IDLE: not a valid request; no pulse, go to LOCK.
- Zero or more than one sel_* high: no pulse; state stays or goes to LOCK per the rules above.
- Exactly one of the six step outputs is high in any pulse cycle; the field and direction used are the latched ones.
- Counter width is $clog2(max(HOLD_CYC, REPEAT_CYC)). No wrap: the counter is always cleared at the terminal count.

## Timing
- Reset values:
  - all six step outputs = 0;
  - busy = 0;
  - state = LOCK;
  - counter = 0.
- rst sampled high at any edge, including mid-hold: the next cycle has all outputs 0 and state LOCK. Any pending pulse is dropped.
- Pulse latency and spacing:
  - valid request first sampled in IDLE at edge t → pulse visible in cycle t+1;
  - second pulse at t+1+HOLD_CYC;
  - later pulses every REPEAT_CYC cycles.
- Release sampled at edge r: no pulse in cycle r+1 or after, even if the terminal count coincides with r.
- Every step output is exactly one cycle wide. busy goes high the cycle after the first pulse is registered.

## Structure
- Shared package watch_pkg holds:
  - state encoding constants (LOCK, IDLE, DELAY, REPEAT);
  - field one-hot constants (SEC=3'b010, MIN=3'b001, HOUR=3'b100), matching the watch control unit's encoding.
- Single flat module; the hold counter is an in-module register. No sub-module is warranted.

## Test plan
All scenarios use HOLD_CYC=8, REPEAT_CYC=3.
- Reset with btn_up held, sel_min=1 → no pulse; after release and re-press at edge t, inc_min pulses in cycle t+1 only.
- btn_up held 20 cycles from edge t, sel_sec=1 → inc_sec high in cycles t+1, t+9, t+12, t+15, t+18; busy high from t+2.
- btn_down tap of 1 cycle, sel_hour=1 → exactly one dec_hour pulse; state returns to IDLE.
- btn_up held into REPEAT, then btn_down asserted → no further pulses; no new step until both buttons are low.
- Hold in DELAY, then switch sel_min→sel_hour → pulses stop, state LOCK; releasing and re-pressing steps the hour.
- en=0, or sel_sec and sel_min both high, with btn_up pressed → no pulses.
- rst asserted mid-REPEAT → all outputs 0 in the next cycle; held button gives no step until released.

Source files
------------

// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : watch_pkg
// Description : Shared constants for the watch time-setting path.
// Revision    : 1.0 - initial release
// ============================================================================
package watch_pkg;

    localparam logic [1:0] c_LOCK   = 2'd0;
    localparam logic [1:0] c_IDLE   = 2'd1;
    localparam logic [1:0] c_DELAY  = 2'd2;
    localparam logic [1:0] c_REPEAT = 2'd3;

    // Field one-hot encoding shared with the watch control unit: {hour, sec, min}
    localparam logic [2:0] c_SEC  = 3'b010;
    localparam logic [2:0] c_MIN  = 3'b001;
    localparam logic [2:0] c_HOUR = 3'b100;

    // Step vector order: {inc_sec, dec_sec, inc_min, dec_min, inc_hour, dec_hour}
    function automatic logic [5:0] step_vec(input logic [2:0] field, input logic up);
        logic [5:0] v;
        v = 6'b000000;
        case (field)
            c_SEC:   v = up ? 6'b100000 : 6'b010000;
            c_MIN:   v = up ? 6'b001000 : 6'b000100;
            c_HOUR:  v = up ? 6'b000010 : 6'b000001;
            default: v = 6'b000000;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/watch_adjust_seq.sv
`default_nettype none
// ============================================================================
// Module      : watch_adjust_seq
// Description : Auto-repeat adjust sequencer producing sec/min/hour step pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module watch_adjust_seq
    import watch_pkg::*;
#(
    parameter int HOLD_CYC   = 50_000_000,
    parameter int REPEAT_CYC = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sel_sec,
    input  logic sel_min,
    input  logic sel_hour,
    input  logic btn_up,
    input  logic btn_down,
    output logic inc_sec,
    output logic dec_sec,
    output logic inc_min,
    output logic dec_min,
    output logic inc_hour,
    output logic dec_hour,
    output logic busy
);

    localparam int c_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int c_CW  = $clog2(c_MAX);
    localparam logic [c_CW-1:0] c_HOLD_LAST   = c_CW'(HOLD_CYC - 1);
    localparam logic [c_CW-1:0] c_REPEAT_LAST = c_CW'(REPEAT_CYC - 1);

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_up;
    logic [2:0]      r_field;
    logic [5:0]      r_step;
    logic            r_busy;

    logic [2:0] w_sel;
    logic       w_valid;
    logic       w_mine;
    logic       w_other;
    logic       w_hold;
    logic       w_release;

    assign w_sel     = {sel_hour, sel_sec, sel_min};
    assign w_valid   = en & $onehot(w_sel) & (btn_up ^ btn_down);
    assign w_mine    = r_up ? btn_up   : btn_down;
    assign w_other   = r_up ? btn_down : btn_up;
    // Hold is checked before terminal count, so a release coinciding with it drops the pulse
    assign w_hold    = w_mine & ~w_other & (w_sel == r_field) & en;
    assign w_release = ~w_mine & ~w_other;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_LOCK;
            r_cnt   <= '0;
            r_up    <= 1'b0;
            r_field <= 3'b000;
            r_step  <= 6'b000000;
            r_busy  <= 1'b0;
        end else begin
            r_step <= 6'b000000;
            r_busy <= (r_state == c_DELAY) || (r_state == c_REPEAT);
            case (r_state)
                c_LOCK: begin
                    if (!btn_up && !btn_down) r_state <= c_IDLE;
                end
                c_IDLE: begin
                    if (btn_up && btn_down) begin
                        r_state <= c_LOCK;
                    end else if (w_valid) begin
                        r_up    <= btn_up;
                        r_field <= w_sel;
                        r_cnt   <= '0;
                        r_step  <= step_vec(w_sel, btn_up);
                        r_state <= c_DELAY;
                    end
                end
                c_DELAY: begin
                    if (w_hold) begin
                        if (r_cnt == c_HOLD_LAST) begin
                            r_cnt   <= '0;
                            r_step  <= step_vec(r_field, r_up);
                            r_state <= c_REPEAT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_state <= w_release ? c_IDLE : c_LOCK;
                    end
                end
                c_REPEAT: begin
                    if (w_hold) begin
                        if (r_cnt == c_REPEAT_LAST) begin
                            r_cnt  <= '0;
                            r_step <= step_vec(r_field, r_up);
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_state <= w_release ? c_IDLE : c_LOCK;
                    end
                end
                default: r_state <= c_LOCK;
            endcase
        end
    end

    assign {inc_sec, dec_sec, inc_min, dec_min, inc_hour, dec_hour} = r_step;
    assign busy = r_busy;

endmodule
`default_nettype wire
